mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the MIPS datapath: steps each instruction through IF/ID/EX/MEM/WB,
//  driving the same control encodings as ctrl_encode_def.v one state at a time. Adds write strobes
//  (PCWr, IRWr) and a req/rdy data-memory handshake with timeout.
//  Sits between the IR fields and the PC/IR/RF/ALU/DM enables of the multi-cycle datapath top.
// PARAMETERS
//  MEM_TIMEOUT  255  max dm_rdy wait cycles in MEM before error halt; 0 = wait forever
//  CNT_W        8    width of MEM wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  op         in   6   IR[31:26], valid from ID onward (IR written in IF)
//  funct      in   6   IR[5:0]
//  bgez_bltz  in   5   IR[20:16]; 5'b00000 = BLTZ, else BGEZ
//  dm_rdy     in   1   data memory completed the access this cycle
//  PCWr       out  1   PC load strobe (PC <= NPC per NPCOp)
//  IRWr       out  1   IR load strobe
//  RFWr       out  1   register file write strobe
//  RegDst     out  2   RD_RT/RD_RD/RD_RA
//  ToReg      out  2   ALU2REG/DM2REG/NPC2REG
//  ALUSrc     out  2   ALUSRC_REG/IMM/SHA/ZERO;  ALUSrc0 out 1: A = shamt
//  EXTOp      out  1   1 = sign-extend imm16
//  ALUOp      out  5   ALU_* code;  NPCOp out 4: NPC_* code
//  DMRe       out  3   DMRE_* (held through MEM);  DMWr out 2: DMWR_* (held through MEM)
//  dm_req     out  1   data access request, high every MEM cycle until dm_rdy
//  instr_done out  1   1-cycle pulse in last state of each instruction
//  halted     out  1   FSM in HALT;  err out 1: sticky, MEM timeout (or illegal op, see CONFIG)
// BEHAVIOUR
//  - States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7. rst -> IF, wait cnt=0, err=0.
//  - While rst=1 all strobes (PCWr,IRWr,RFWr,dm_req,instr_done) and DMWr/DMRe forced NOP/0; others 0.
//  - Outputs are combinational in (state, op, funct, bgez_bltz); no output has a default of X.
//  - IF: IRWr=1 -> ID (instruction memory is single-cycle).
//  - ID: J: PCWr=1 NPC_JUMP. JAL: also RFWr=1 RD_RA NPC2REG. JR: PCWr=1 NPC_JUMPR. JALR: JR + RFWr
//    (RD_RA, NPC2REG). All four -> IF with instr_done. Others -> EX.
//  - EX: ALU/shift/imm ops: ALUOp/ALUSrc/EXTOp per op -> WB. Branches (BEQ,BNE,BGTZ,BLEZ,BLTZ,BGEZ):
//    ALU_SUB, PCWr=1 with branch NPCOp (NPC resolves taken), instr_done -> IF. Loads/stores:
//    ALU_ADD, ALUSrc IMM, EXTOp=1 -> MEM.
//  - MEM: dm_req=1, DMRe/DMWr per op, ALU address controls held. dm_rdy=1: store -> PCWr=1 NPC_PLUS4,
//    instr_done, IF; load -> WB. dm_rdy=0: stay, cnt++. cnt==MEM_TIMEOUT (nonzero) and !dm_rdy ->
//    HALT, err=1. cnt clears on leaving MEM. dm_rdy ignored outside MEM.
//  - WB: RFWr=1, PCWr=1 NPC_PLUS4, instr_done; R/imm: ToReg ALU2REG, RegDst RD/RT; load: DM2REG, RD_RT -> IF.
//  - HALT: all strobes 0, NPCOp NPC_NOP, halted=1; exits only on rst.
//  - Latency (dm_rdy immediate): J/JAL/JR/JALR 2, branch 3, ALU 4, store 4, load 5 cycles; +1 per wait.
//  - rst mid-instruction: next cycle in IF, no partial RF/DM write, err cleared.
//  - SLL/SRL/SRA: ALUSrc0=1, ALUSrc SHA, EXTOp=0 in EX.
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined: undefined op (or undefined funct under R_TYPE) in ID -> HALT, err=1,
//   no PCWr. Not defined: treated as NOP in ID: PCWr=1 NPC_PLUS4, instr_done, -> IF, err unchanged.
// TESTING
//  T1 reset: rst=1 2 cycles mid-MEM of SW -> DMWr=NOP, dm_req=0 during rst; state IF, IRWr=1 next cycle.
//  T2 ADDU $3,$1,$2 (op 0, funct 0x21) -> IRWr@c0, EX ALU_ADDU@c2, RFWr+PCWr RD_RD ALU2REG @c3, done @c3.
//  T3 LW with dm_rdy low 3 cycles -> dm_req high 4 MEM cycles, DMRe=LW held, WB RFWr DM2REG; total 8 cycles.
//  T4 JAL then BLTZ (rt=0) then BGEZ (rt=1) -> ID PCWr NPC_JUMP RFWr RD_RA; EX NPC_BRANCH_BLTZ; then _BGEZ.
//  T5 MEM_TIMEOUT=4, SW with dm_rdy stuck 0 -> HALT after 5 MEM cycles, err=1, halted=1, no PCWr; rst clears.
//  T6 op=6'h3F: with MC_ILLEGAL_TRAP_EN -> HALT err=1 at c2; without -> PCWr NPC_PLUS4 at c1, next IF c2.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the MIPS datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and drives the datapath
// control encodings one state at a time. Data memory is accessed with a
// req/rdy handshake that halts with err if dm_rdy takes longer than
// MEM_TIMEOUT cycles (0 disables the timeout).
// Optional feature: define MC_ILLEGAL_TRAP_EN to halt with err on an
// undefined opcode/funct; otherwise such instructions retire as a NOP.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] bgez_bltz,
  input  logic       dm_rdy,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic [1:0] RegDst,
  output logic [1:0] ToReg,
  output logic [1:0] ALUSrc,
  output logic       ALUSrc0,
  output logic       EXTOp,
  output logic [4:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [2:0] DMRe,
  output logic [1:0] DMWr,
  output logic       dm_req,
  output logic       instr_done,
  output logic       halted,
  output logic       err
);

  // Datapath control encodings
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] ALU2REG = 2'd0, DM2REG = 2'd1, NPC2REG = 2'd2;
  localparam logic [1:0] ALUSRC_REG = 2'd0, ALUSRC_IMM = 2'd1,
                         ALUSRC_SHA = 2'd2, ALUSRC_ZERO = 2'd3;
  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADDU = 5'd1, ALU_ADD = 5'd2,
                         ALU_SUBU = 5'd3, ALU_SUB = 5'd4, ALU_AND = 5'd5,
                         ALU_OR = 5'd6, ALU_NOR = 5'd7, ALU_XOR = 5'd8,
                         ALU_SLT = 5'd9, ALU_SLTU = 5'd10, ALU_SLL = 5'd11,
                         ALU_SRL = 5'd12, ALU_SRA = 5'd13, ALU_LUI = 5'd14,
                         ALU_SLLV = 5'd15, ALU_SRLV = 5'd16, ALU_SRAV = 5'd17;
  localparam logic [3:0] NPC_PLUS4 = 4'd0, NPC_BRANCH_BEQ = 4'd1,
                         NPC_BRANCH_BNE = 4'd2, NPC_BRANCH_BGTZ = 4'd3,
                         NPC_BRANCH_BLEZ = 4'd4, NPC_BRANCH_BLTZ = 4'd5,
                         NPC_BRANCH_BGEZ = 4'd6, NPC_JUMP = 4'd7,
                         NPC_JUMPR = 4'd8, NPC_NOP = 4'd15;
  localparam logic [2:0] DMRE_NOP = 3'd0, DMRE_LB = 3'd1, DMRE_LBU = 3'd2,
                         DMRE_LH = 3'd3, DMRE_LHU = 3'd4, DMRE_LW = 3'd5;
  localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SB = 2'd1, DMWR_SH = 2'd2,
                         DMWR_SW = 2'd3;

  // Opcodes and R-type function codes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02,
                         OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21,
                         OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25,
                         OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
                         FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_RALU, C_IALU, C_BRANCH, C_LOAD, C_STORE,
    C_J, C_JAL, C_JR, C_JALR
  } cls_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err_q, err_next;

  cls_t       cls;
  logic [4:0] d_aluop;
  logic [1:0] d_alusrc;
  logic       d_alusrc0;
  logic       d_extop;
  logic [3:0] d_npc_br;
  logic [2:0] d_dmre;
  logic [1:0] d_dmwr;

  // Instruction decode: classify the instruction and pick its ALU/DM controls
  always_comb begin
    cls       = C_ILLEGAL;
    d_aluop   = ALU_NOP;
    d_alusrc  = ALUSRC_REG;
    d_alusrc0 = 1'b0;
    d_extop   = 1'b0;
    d_npc_br  = NPC_PLUS4;
    d_dmre    = DMRE_NOP;
    d_dmwr    = DMWR_NOP;
    case (op)
      OP_RTYPE: begin
        cls = C_RALU;
        case (funct)
          FN_SLL:  begin d_aluop = ALU_SLL; d_alusrc = ALUSRC_SHA; d_alusrc0 = 1'b1; end
          FN_SRL:  begin d_aluop = ALU_SRL; d_alusrc = ALUSRC_SHA; d_alusrc0 = 1'b1; end
          FN_SRA:  begin d_aluop = ALU_SRA; d_alusrc = ALUSRC_SHA; d_alusrc0 = 1'b1; end
          FN_SLLV: d_aluop = ALU_SLLV;
          FN_SRLV: d_aluop = ALU_SRLV;
          FN_SRAV: d_aluop = ALU_SRAV;
          FN_ADD:  d_aluop = ALU_ADD;
          FN_ADDU: d_aluop = ALU_ADDU;
          FN_SUB:  d_aluop = ALU_SUB;
          FN_SUBU: d_aluop = ALU_SUBU;
          FN_AND:  d_aluop = ALU_AND;
          FN_OR:   d_aluop = ALU_OR;
          FN_XOR:  d_aluop = ALU_XOR;
          FN_NOR:  d_aluop = ALU_NOR;
          FN_SLT:  d_aluop = ALU_SLT;
          FN_SLTU: d_aluop = ALU_SLTU;
          FN_JR:   cls = C_JR;
          FN_JALR: cls = C_JALR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        cls      = C_BRANCH;
        d_aluop  = ALU_SUB;
        d_alusrc = ALUSRC_ZERO;
        d_npc_br = (bgez_bltz == 5'd0) ? NPC_BRANCH_BLTZ : NPC_BRANCH_BGEZ;
      end
      OP_BEQ:  begin cls = C_BRANCH; d_aluop = ALU_SUB; d_npc_br = NPC_BRANCH_BEQ; end
      OP_BNE:  begin cls = C_BRANCH; d_aluop = ALU_SUB; d_npc_br = NPC_BRANCH_BNE; end
      OP_BLEZ: begin cls = C_BRANCH; d_aluop = ALU_SUB; d_alusrc = ALUSRC_ZERO; d_npc_br = NPC_BRANCH_BLEZ; end
      OP_BGTZ: begin cls = C_BRANCH; d_aluop = ALU_SUB; d_alusrc = ALUSRC_ZERO; d_npc_br = NPC_BRANCH_BGTZ; end
      OP_ADDI:  begin cls = C_IALU; d_aluop = ALU_ADD;  d_alusrc = ALUSRC_IMM; d_extop = 1'b1; end
      OP_ADDIU: begin cls = C_IALU; d_aluop = ALU_ADDU; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; end
      OP_SLTI:  begin cls = C_IALU; d_aluop = ALU_SLT;  d_alusrc = ALUSRC_IMM; d_extop = 1'b1; end
      OP_SLTIU: begin cls = C_IALU; d_aluop = ALU_SLTU; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; end
      OP_ANDI:  begin cls = C_IALU; d_aluop = ALU_AND;  d_alusrc = ALUSRC_IMM; end
      OP_ORI:   begin cls = C_IALU; d_aluop = ALU_OR;   d_alusrc = ALUSRC_IMM; end
      OP_XORI:  begin cls = C_IALU; d_aluop = ALU_XOR;  d_alusrc = ALUSRC_IMM; end
      OP_LUI:   begin cls = C_IALU; d_aluop = ALU_LUI;  d_alusrc = ALUSRC_IMM; end
      OP_LB:  begin cls = C_LOAD;  d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmre = DMRE_LB;  end
      OP_LH:  begin cls = C_LOAD;  d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmre = DMRE_LH;  end
      OP_LW:  begin cls = C_LOAD;  d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmre = DMRE_LW;  end
      OP_LBU: begin cls = C_LOAD;  d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmre = DMRE_LBU; end
      OP_LHU: begin cls = C_LOAD;  d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmre = DMRE_LHU; end
      OP_SB:  begin cls = C_STORE; d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmwr = DMWR_SB; end
      OP_SH:  begin cls = C_STORE; d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmwr = DMWR_SH; end
      OP_SW:  begin cls = C_STORE; d_aluop = ALU_ADD; d_alusrc = ALUSRC_IMM; d_extop = 1'b1; d_dmwr = DMWR_SW; end
      OP_J:   cls = C_J;
      OP_JAL: cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

  // State, MEM wait counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err_q <= err_next;
    end
  end

  // Next-state and per-state control outputs; reset forces every output low
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    err_next   = err_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    RegDst     = RD_RT;
    ToReg      = ALU2REG;
    ALUSrc     = ALUSRC_REG;
    ALUSrc0    = 1'b0;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = NPC_PLUS4;
    DMRe       = DMRE_NOP;
    DMWr       = DMWR_NOP;
    dm_req     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    err        = err_q;
    case (state)
      S_IF: begin
        IRWr       = 1'b1;
        state_next = S_ID;
      end
      S_ID: begin
        case (cls)
          C_J: begin
            PCWr = 1'b1; NPCOp = NPC_JUMP; instr_done = 1'b1; state_next = S_IF;
          end
          C_JAL: begin
            PCWr = 1'b1; NPCOp = NPC_JUMP; RFWr = 1'b1; RegDst = RD_RA; ToReg = NPC2REG;
            instr_done = 1'b1; state_next = S_IF;
          end
          C_JR: begin
            PCWr = 1'b1; NPCOp = NPC_JUMPR; instr_done = 1'b1; state_next = S_IF;
          end
          C_JALR: begin
            PCWr = 1'b1; NPCOp = NPC_JUMPR; RFWr = 1'b1; RegDst = RD_RA; ToReg = NPC2REG;
            instr_done = 1'b1; state_next = S_IF;
          end
          C_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_next = S_HALT;
            err_next   = 1'b1;
`else
            PCWr = 1'b1; NPCOp = NPC_PLUS4; instr_done = 1'b1; state_next = S_IF;
`endif
          end
          default: state_next = S_EX;
        endcase
      end
      S_EX: begin
        ALUOp   = d_aluop;
        ALUSrc  = d_alusrc;
        ALUSrc0 = d_alusrc0;
        EXTOp   = d_extop;
        case (cls)
          C_BRANCH: begin
            PCWr = 1'b1; NPCOp = d_npc_br; instr_done = 1'b1; state_next = S_IF;
          end
          C_LOAD, C_STORE: state_next = S_MEM;
          default:         state_next = S_WB;
        endcase
      end
      S_MEM: begin
        dm_req  = 1'b1;
        ALUOp   = d_aluop;
        ALUSrc  = d_alusrc;
        ALUSrc0 = d_alusrc0;
        EXTOp   = d_extop;
        DMRe    = d_dmre;
        DMWr    = d_dmwr;
        if (dm_rdy) begin
          if (cls == C_STORE) begin
            PCWr = 1'b1; NPCOp = NPC_PLUS4; instr_done = 1'b1; state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else if ((MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT))) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else begin
          cnt_next = (MEM_TIMEOUT != 0) ? cnt + CNT_W'(1) : cnt;
        end
      end
      S_WB: begin
        RFWr       = 1'b1;
        PCWr       = 1'b1;
        NPCOp      = NPC_PLUS4;
        instr_done = 1'b1;
        if (cls == C_LOAD) begin
          ToReg = DM2REG; RegDst = RD_RT;
        end else if (cls == C_RALU) begin
          ToReg = ALU2REG; RegDst = RD_RD;
        end else begin
          ToReg = ALU2REG; RegDst = RD_RT;
        end
        state_next = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
        NPCOp  = NPC_NOP;
      end
      default: state_next = S_IF;
    endcase
    if (rst) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RFWr       = 1'b0;
      RegDst     = RD_RT;
      ToReg      = ALU2REG;
      ALUSrc     = ALUSRC_REG;
      ALUSrc0    = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = ALU_NOP;
      NPCOp      = NPC_PLUS4;
      DMRe       = DMRE_NOP;
      DMWr       = DMWR_NOP;
      dm_req     = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
      err        = 1'b0;
    end
  end

endmodule
